// File: rtl/input_debouncer.sv
// input_debouncer: four-channel front-panel debouncer.
// Buttons also emit a one-cycle pulse on each debounced press.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic sync_play_button,
    input  logic sync_record_button,
    input  logic sync_play_track_switch,
    input  logic sync_record_track_switch,
    output logic play_level,
    output logic record_level,
    output logic play_pressed,
    output logic record_pressed,
    output logic play_track,
    output logic record_track
);

    localparam int NCH = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // channel order: play button, record button, play switch, record switch
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   stable;
    logic [NCH-1:0]   stable_nxt;
    logic [CNT_W-1:0] cnt     [NCH];
    logic [CNT_W-1:0] cnt_nxt [NCH];

    assign raw = {sync_record_track_switch, sync_play_track_switch,
                  sync_record_button, sync_play_button};

    // Count consecutive samples that disagree with the debounced value.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt[i] = '0;
            if (raw[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX)
                    stable_nxt[i] = raw[i];
                else
                    cnt_nxt[i] = cnt[i] + 1'b1;
            end
        end
    end

    // Register channel state and the press pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable         <= '0;
            play_pressed   <= 1'b0;
            record_pressed <= 1'b0;
            for (int i = 0; i < NCH; i++)
                cnt[i] <= '0;
        end else begin
            stable         <= stable_nxt;
            play_pressed   <= stable_nxt[0] & ~stable[0];
            record_pressed <= stable_nxt[1] & ~stable[1];
            for (int i = 0; i < NCH; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

    assign play_level   = stable[0];
    assign record_level = stable[1];
    assign play_track   = stable[2];
    assign record_track = stable[3];

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed plus random checks of input_debouncer
// against a sample-history reference model.
module tb_input_debouncer;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic play_b = 1'b0;
    logic rec_b = 1'b0;
    logic play_s = 1'b0;
    logic rec_s = 1'b0;
    logic play_level, record_level, play_pressed, record_pressed;
    logic play_track, record_track;

    int checks = 0;
    int errors = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .sync_play_button         (play_b),
        .sync_record_button       (rec_b),
        .sync_play_track_switch   (play_s),
        .sync_record_track_switch (rec_s),
        .play_level               (play_level),
        .record_level             (record_level),
        .play_pressed             (play_pressed),
        .record_pressed           (record_pressed),
        .play_track               (play_track),
        .record_track             (record_track)
    );

    always #5 clock = ~clock;

    // Reference: history of raw samples; a channel flips once its last
    // D samples since its previous flip all disagree with its level.
    logic [3:0] hist[$];
    logic [3:0] m_stable = '0;
    logic [1:0] m_pulse = '0;
    logic [3:0] prev_s;
    int since[4] = '{default: 0};
    bit ok;

    always @(posedge clock) begin
        if (reset) begin
            hist.delete();
            m_stable = '0;
            m_pulse = '0;
            since = '{default: 0};
        end else begin
            prev_s = m_stable;
            hist.push_back({rec_s, play_s, rec_b, play_b});
            for (int i = 0; i < 4; i++) begin
                ok = (hist.size() - since[i]) >= D;
                if (ok)
                    for (int k = 1; k <= D; k++)
                        if (hist[hist.size() - k][i] == m_stable[i]) ok = 0;
                if (ok) begin
                    m_stable[i] = ~m_stable[i];
                    since[i] = hist.size();
                end
            end
            m_pulse = m_stable[1:0] & ~prev_s[1:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc, play_cnt, rec_cnt, play_first, rec_first;

    task automatic clear_counts();
        cyc = 1;
        play_cnt = 0;
        rec_cnt = 0;
        play_first = 0;
        rec_first = 0;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        check("model",
              {26'd0, record_track, play_track, record_pressed,
               play_pressed, record_level, play_level},
              {26'd0, m_stable[3], m_stable[2], m_pulse[1],
               m_pulse[0], m_stable[1], m_stable[0]});
        if (play_pressed === 1'b1) begin
            play_cnt++;
            if (play_first == 0) play_first = cyc;
        end
        if (record_pressed === 1'b1) begin
            rec_cnt++;
            if (rec_first == 0) rec_first = cyc;
        end
        cyc++;
    endtask

    task automatic set_in(input logic [3:0] v);
        {rec_s, play_s, rec_b, play_b} = v;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        clear_counts();
    endtask

    logic [3:0] bounce;

    initial begin
        clear_counts();
        // reset held with all inputs high
        set_in(4'hf);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outs",
                  {26'd0, record_track, play_track, record_pressed,
                   play_pressed, record_level, play_level}, 32'd0);
        end
        reset = 1'b0;
        clear_counts();
        repeat (8) step();
        check("rst_play_first", play_first, 4);
        check("rst_play_cnt", play_cnt, 1);
        check("rst_rec_first", rec_first, 4);
        check("rst_tracks", {30'd0, record_track, play_track}, 32'd3);

        // clean press on play only
        set_in(4'h0);
        do_reset(2);
        play_b = 1'b1;
        repeat (7) step();
        check("press_first", play_first, 4);
        check("press_cnt", play_cnt, 1);
        check("press_rec_cnt", rec_cnt, 0);

        // bounce on record, then settle
        set_in(4'h0);
        do_reset(2);
        bounce = 4'b0111;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) begin
                rec_b = bounce[3 - i];
                step();
            end
        check("bounce_level", record_level, 0);
        check("bounce_cnt", rec_cnt, 0);
        rec_b = 1'b1;
        repeat (5) step();
        check("bounce_settle_cnt", rec_cnt, 1);

        // release and re-press
        set_in(4'h0);
        do_reset(2);
        play_b = 1'b1;
        repeat (10) step();
        play_b = 1'b0;
        repeat (3) step();
        check("release_hold", play_level, 1);
        step();
        check("release_fall", play_level, 0);
        repeat (2) step();
        play_b = 1'b1;
        repeat (6) step();
        check("repress_cnt", play_cnt, 2);

        // simultaneous change on all channels
        set_in(4'h0);
        do_reset(2);
        set_in(4'hf);
        repeat (6) step();
        check("simul_play_first", play_first, 4);
        check("simul_rec_first", rec_first, 4);
        check("simul_cnts", play_cnt + rec_cnt, 2);

        // reset in the middle of a count
        set_in(4'h0);
        do_reset(2);
        play_b = 1'b1;
        repeat (3) step();
        do_reset(1);
        repeat (7) step();
        check("midrst_first", play_first, 4);
        check("midrst_cnt", play_cnt, 1);

        // random traffic with occasional resets
        set_in(4'h0);
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5) == 0) begin
                    case (i)
                        0: play_b = ~play_b;
                        1: rec_b = ~rec_b;
                        2: play_s = ~play_s;
                        default: rec_s = ~rec_s;
                    endcase
                end
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
